// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges ALU and load results onto the register-file write port, diverting R15 to the PC
// Optional feature: define WB_LOAD_BYPASS_EN to let a load skip the FIFO when the FIFO is empty and the ALU is idle.
module writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [3:0]  alu_rd,
  input  logic [31:0] alu_result,
  output logic        alu_stall,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [3:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        we3,
  output logic [3:0]  wa3,
  output logic [31:0] wd3,
  output logic        pc_we,
  output logic [31:0] pc_wdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [3:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [SW-1:0] starve_cnt;

  logic          empty;
  logic          full;
  logic          force_ld;
  logic          alu_win;
  logic          pop;
  logic          push;
  logic          byp;
  logic          win_valid;
  logic [3:0]    win_rd;
  logic [31:0]   win_data;

  assign empty    = (count == '0);
  assign full     = (count == (AW + 1)'(DEPTH));
  assign ld_ready = !full && !reset;

  // The queue head is forced out once the ALU has starved it long enough.
  assign force_ld  = !empty && (starve_cnt == SW'(STARVE_LIMIT));
  assign alu_stall = force_ld;
  assign alu_win   = alu_valid && !force_ld;
  assign pop       = !empty && !alu_win;

`ifdef WB_LOAD_BYPASS_EN
  assign byp = empty && !alu_valid && ld_valid && !reset;
`else
  assign byp = 1'b0;
`endif

  assign push = ld_valid && ld_ready && !byp;

  // Select this cycle's single writer: ALU, FIFO head, or a bypassed load.
  always_comb begin
    win_valid = 1'b0;
    win_rd    = '0;
    win_data  = '0;
    if (alu_win) begin
      win_valid = 1'b1;
      win_rd    = alu_rd;
      win_data  = alu_result;
    end else if (pop) begin
      win_valid = 1'b1;
      win_rd    = fifo_rd[rd_ptr];
      win_data  = fifo_data[rd_ptr];
    end else if (byp) begin
      win_valid = 1'b1;
      win_rd    = ld_rd;
      win_data  = ld_data;
    end
  end

  // Load FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= ld_rd;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  // FIFO pointers and occupancy; reset drops any queued loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Count consecutive ALU wins while a load waits; saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset || pop || empty) begin
      starve_cnt <= '0;
    end else if (alu_win && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Register the winner onto either the register-file port or the PC port.
  always_ff @(posedge clk) begin
    if (reset) begin
      we3      <= 1'b0;
      wa3      <= '0;
      wd3      <= '0;
      pc_we    <= 1'b0;
      pc_wdata <= '0;
    end else begin
      we3   <= 1'b0;
      pc_we <= 1'b0;
      if (win_valid) begin
        if (win_rd == 4'd15) begin
          pc_we    <= 1'b1;
          pc_wdata <= win_data;
        end else begin
          we3 <= 1'b1;
          wa3 <= win_rd;
          wd3 <= win_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed scoreboard bench for writeback_arbiter (default build, no load bypass)
module tb_writeback_arbiter;

  localparam int NONE = 0;
  localparam int RF   = 1;
  localparam int PC   = 2;
  localparam int SKIP = -1;

  typedef struct {
    int          kind;
    logic [3:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [31:0] alu_result;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_rd;
  logic [31:0] ld_data;
  logic        we3;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic        pc_we;
  logic [31:0] pc_wdata;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_result (alu_result),
    .alu_stall  (alu_stall),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .we3        (we3),
    .wa3        (wa3),
    .wd3        (wd3),
    .pc_we      (pc_we),
    .pc_wdata   (pc_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check handshake outputs, push the expected
  // write for this cycle, then pop and compare it after the edge.
  task automatic step(input string tag, input logic rst,
                      input logic av, input logic [3:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [3:0] lrd, input logic [31:0] ldd,
                      input int e_stall, input int e_rdy,
                      input int e_kind, input logic [3:0] e_rd, input logic [31:0] e_data);
    exp_t e;
    reset      = rst;
    alu_valid  = av;
    alu_rd     = ard;
    alu_result = ad;
    ld_valid   = lv;
    ld_rd      = lrd;
    ld_data    = ldd;
    #1;
    if (e_stall != SKIP) chk({tag, " alu_stall"}, {31'd0, alu_stall}, e_stall);
    if (e_rdy != SKIP)   chk({tag, " ld_ready"}, {31'd0, ld_ready}, e_rdy);
    exp_q.push_back('{kind: e_kind, rd: e_rd, data: e_data});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    case (e.kind)
      RF: begin
        chk({tag, " we3"}, {31'd0, we3}, 32'd1);
        chk({tag, " wa3"}, {28'd0, wa3}, {28'd0, e.rd});
        chk({tag, " wd3"}, wd3, e.data);
        chk({tag, " pc_we"}, {31'd0, pc_we}, 32'd0);
      end
      PC: begin
        chk({tag, " pc_we"}, {31'd0, pc_we}, 32'd1);
        chk({tag, " pc_wdata"}, pc_wdata, e.data);
        chk({tag, " we3"}, {31'd0, we3}, 32'd0);
      end
      default: begin
        chk({tag, " we3"}, {31'd0, we3}, 32'd0);
        chk({tag, " pc_we"}, {31'd0, pc_we}, 32'd0);
      end
    endcase
  endtask

  initial begin
    reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    @(posedge clk);
    #1;

    // Reset values
    step("rst", 1, 0, 0, 0, 0, 0, 0, SKIP, 0, NONE, 0, 0);
    chk("rst wa3", {28'd0, wa3}, 32'd0);
    chk("rst wd3", wd3, 32'd0);
    chk("rst pc_wdata", pc_wdata, 32'd0);

    // 1. ALU only
    step("alu", 0, 1, 4'd1, 32'hAAAAAAAA, 0, 0, 0, 0, 1, RF, 4'd1, 32'hAAAAAAAA);

    // 2. Load only: two-cycle latency
    step("ld0", 0, 0, 0, 0, 1, 4'd2, 32'h55555555, 0, 1, NONE, 0, 0);
    step("ld1", 0, 0, 0, 0, 0, 0, 0, 0, 1, RF, 4'd2, 32'h55555555);
    step("ld2", 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0, 0);

    // 3. R15 divert
    step("r15", 0, 1, 4'd15, 32'h00000100, 0, 0, 0, 0, 1, PC, 4'd15, 32'h00000100);
    chk("r15 wa3 held", {28'd0, wa3}, 32'd2);

    // 4. Fill under continuous ALU, full blocks a push even while popping
    step("fill0", 0, 1, 4'd8,  32'h80000000, 1, 4'd3, 32'h33333333, 0, 1, RF, 4'd8,  32'h80000000);
    step("fill1", 0, 1, 4'd9,  32'h90000000, 1, 4'd4, 32'h44444444, 0, 1, RF, 4'd9,  32'h90000000);
    step("fill2", 0, 1, 4'd10, 32'hA0000000, 1, 4'd5, 32'h55555555, 0, 1, RF, 4'd10, 32'hA0000000);
    step("fill3", 0, 1, 4'd11, 32'hB0000000, 1, 4'd6, 32'h66666666, 0, 1, RF, 4'd11, 32'hB0000000);
    step("full",  0, 1, 4'd12, 32'hC0000000, 1, 4'd7, 32'h77777777, 1, 0, RF, 4'd3,  32'h33333333);
    step("held",  0, 1, 4'd12, 32'hC0000000, 0, 0, 0, 0, 1, RF, 4'd12, 32'hC0000000);
    step("drn4",  0, 0, 0, 0, 0, 0, 0, 0, 1, RF, 4'd4, 32'h44444444);
    step("drn5",  0, 0, 0, 0, 0, 0, 0, 0, 1, RF, 4'd5, 32'h55555555);
    step("drn6",  0, 0, 0, 0, 0, 0, 0, 0, 1, RF, 4'd6, 32'h66666666);
    step("drnE",  0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0, 0);

    // 5. Starvation guard
    step("stv0", 0, 0, 0, 0, 1, 4'd1, 32'h11111111, 0, 1, NONE, 0, 0);
    step("stv1", 0, 1, 4'd7, 32'h70000001, 0, 0, 0, 0, 1, RF, 4'd7, 32'h70000001);
    step("stv2", 0, 1, 4'd7, 32'h70000002, 0, 0, 0, 0, 1, RF, 4'd7, 32'h70000002);
    step("stv3", 0, 1, 4'd7, 32'h70000003, 0, 0, 0, 0, 1, RF, 4'd7, 32'h70000003);
    step("stv4", 0, 1, 4'd7, 32'h70000004, 0, 0, 0, 1, 1, RF, 4'd1, 32'h11111111);
    step("stv5", 0, 1, 4'd7, 32'h70000004, 0, 0, 0, 0, 1, RF, 4'd7, 32'h70000004);
    step("stv6", 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0, 0);

    // 6. Reset mid-drain drops queued loads
    step("rmd0", 0, 1, 4'd8,  32'h08080808, 1, 4'd2, 32'h22222222, 0, 1, RF, 4'd8,  32'h08080808);
    step("rmd1", 0, 1, 4'd9,  32'h09090909, 1, 4'd3, 32'h33333333, 0, 1, RF, 4'd9,  32'h09090909);
    step("rmd2", 0, 1, 4'd10, 32'h0A0A0A0A, 1, 4'd4, 32'h44444444, 0, 1, RF, 4'd10, 32'h0A0A0A0A);
    step("rmdR", 1, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, 0);
    step("rmd3", 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0, 0);
    step("rmd4", 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0, 0);
    step("rmd5", 0, 1, 4'd5, 32'h05050505, 0, 0, 0, 0, 1, RF, 4'd5, 32'h05050505);
    step("rmd6", 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0, 0);

    chk("scoreboard empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
